// File: rtl/fpu_norm_seq.sv
// fpu_norm_seq: multi-cycle mantissa normalizer whose left shift is clamped by the exponent
module fpu_pri_encoder #(
  parameter int WIDTH     = 64,
  parameter int WIDTH_LOG = 6
) (
  input  logic [WIDTH-1:0]     vec_i,
  output logic [WIDTH_LOG-1:0] msb_o
);
  always_comb begin
    msb_o = '0;
    for (int i = 0; i < WIDTH; i++) msb_o = vec_i[i] ? WIDTH_LOG'(i) : msb_o;
  end
endmodule

module fpu_norm_seq #(
  parameter int WIDTH     = 55,
  parameter int WIDTH_LOG = 6,
  parameter int EXP_W     = 11,
  parameter int STEP      = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_mant,
  input  logic [EXP_W-1:0] in_exp,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_mant,
  output logic [EXP_W-1:0] out_exp,
  output logic             out_zero,
  output logic             out_denorm,
  output logic             busy
);
  localparam int EW = 2 ** WIDTH_LOG;
  localparam int CW = (EXP_W > WIDTH_LOG ? EXP_W : WIDTH_LOG) + 1;
  typedef enum logic [1:0] {IDLE, ENC, SHIFT, DONE} state_t;
  state_t state_q, state_d;
  logic [WIDTH-1:0] mant_q, mant_d;
  logic [EXP_W-1:0] exp_q, exp_d, rem_q, rem_d, sh, amt;
  logic zero_q, zero_d, denorm_q, denorm_d, fits, nz;
  logic [EW-1:0] enc_vec;
  logic [WIDTH_LOG-1:0] idx;
  logic [CW-1:0] lz;
  assign enc_vec = EW'(mant_q);
  fpu_pri_encoder #(.WIDTH(EW), .WIDTH_LOG(WIDTH_LOG)) u_enc (.vec_i(enc_vec), .msb_o(idx));
  assign nz   = |mant_q;
  assign lz   = CW'(WIDTH - 1) - CW'(idx);
  // when lz >= exp the shift is limited to exp so the exponent bottoms out at zero
  assign fits = lz < CW'(exp_q);
  assign sh   = fits ? EXP_W'(lz) : exp_q;
  assign amt  = (rem_q < EXP_W'(STEP)) ? rem_q : EXP_W'(STEP);
  always_comb begin
    state_d  = state_q;
    mant_d   = mant_q;
    exp_d    = exp_q;
    rem_d    = rem_q;
    zero_d   = zero_q;
    denorm_d = denorm_q;
    case (state_q)
      IDLE: if (in_valid) begin
        state_d  = ENC;
        mant_d   = in_mant;
        exp_d    = in_exp;
        rem_d    = '0;
        zero_d   = 1'b0;
        denorm_d = 1'b0;
      end
      ENC: if (!nz) begin
        state_d = DONE;
        mant_d  = '0;
        exp_d   = '0;
        zero_d  = 1'b1;
      end else begin
        state_d  = (sh != '0) ? SHIFT : DONE;
        exp_d    = fits ? exp_q - sh : '0;
        denorm_d = !fits;
        rem_d    = sh;
      end
      SHIFT: begin
        mant_d  = mant_q << amt;
        rem_d   = rem_q - amt;
        state_d = (rem_q == amt) ? DONE : SHIFT;
      end
      DONE: state_d = out_ready ? IDLE : DONE;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      mant_q   <= '0;
      exp_q    <= '0;
      rem_q    <= '0;
      zero_q   <= 1'b0;
      denorm_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      mant_q   <= mant_d;
      exp_q    <= exp_d;
      rem_q    <= rem_d;
      zero_q   <= zero_d;
      denorm_q <= denorm_d;
    end
  end
  assign in_ready   = state_q == IDLE;
  assign out_valid  = state_q == DONE;
  assign busy       = state_q != IDLE;
  assign out_mant   = mant_q;
  assign out_exp    = exp_q;
  assign out_zero   = zero_q;
  assign out_denorm = denorm_q;
endmodule

// File: tb/tb_fpu_norm_seq.sv
// tb_fpu_norm_seq: directed vectors against a behavioural normalizer model
module tb_fpu_norm_seq;
  localparam int W = 55;
  localparam int EXPW = 11;
  localparam int ST = 16;
  logic clk = 1'b0, rst = 1'b1, in_valid = 1'b0, out_ready = 1'b0;
  logic [W-1:0] in_mant = '0;
  logic [EXPW-1:0] in_exp = '0;
  logic in_ready, out_valid, out_zero, out_denorm, busy;
  logic [W-1:0] out_mant;
  logic [EXPW-1:0] out_exp;
  int tests = 0, fails = 0;
  logic [W-1:0] em;
  int ee, elat, cyc;
  logic ez, ed, pend = 1'b0, seen;

  fpu_norm_seq dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_mant(in_mant), .in_exp(in_exp), .out_valid(out_valid), .out_ready(out_ready),
    .out_mant(out_mant), .out_exp(out_exp), .out_zero(out_zero),
    .out_denorm(out_denorm), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
    end
  endtask

  // Normalization stated directly: shift by the leading-zero count, limited by the exponent
  function automatic void model(input logic [W-1:0] m, input int e);
    int idx, lz, sh;
    if (m == '0) begin
      em = '0; ee = 0; ez = 1'b1; ed = 1'b0; elat = 2;
      return;
    end
    idx = 0;
    for (int i = 0; i < W; i++) if (m[i]) idx = i;
    lz = W - 1 - idx;
    sh = (lz < e) ? lz : e;
    em = m << sh;
    ee = (lz < e) ? e - lz : 0;
    ez = 1'b0;
    ed = !(lz < e);
    elat = 2 + (sh + ST - 1) / ST;
  endfunction

  always @(posedge clk) begin
    if (rst) pend = 1'b0;
    else begin
      if (out_valid && out_ready) pend = 1'b0;
      if (in_valid && in_ready) begin
        model(in_mant, int'(in_exp));
        pend = 1'b1; cyc = 0; seen = 1'b0;
      end
    end
  end

  always @(negedge clk) begin
    if (pend) begin
      cyc++;
      if (out_valid) begin
        if (!seen) begin chk("m_latency", cyc, elat); seen = 1'b1; end
        chk("m_mant", out_mant, em);
        chk("m_exp", out_exp, ee);
        chk("m_zero", out_zero, ez);
        chk("m_denorm", out_denorm, ed);
      end else if (cyc > elat) begin
        chk("m_late", cyc, elat);
        pend = 1'b0;
      end
    end
  end

  task automatic start(input logic [W-1:0] m, input logic [EXPW-1:0] e);
    @(negedge clk);
    in_valid = 1'b1; in_mant = m; in_exp = e;
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic wait_done(input int xl);
    int n = 1;
    while (!out_valid && n < 200) begin @(negedge clk); n++; end
    chk("latency", n, xl);
  endtask

  task automatic release_out();
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    chk("idle_after_ready", in_ready, 1'b1);
  endtask

  task automatic run(input logic [W-1:0] m, input logic [EXPW-1:0] e, input logic [W-1:0] xm,
                     input int xe, input logic xz, input logic xd, input int xl);
    start(m, e);
    wait_done(xl);
    chk("mant", out_mant, xm);
    chk("exp", out_exp, xe);
    chk("zero", out_zero, xz);
    chk("denorm", out_denorm, xd);
    release_out();
  endtask

  initial begin
    repeat (3) @(negedge clk);
    chk("rst_in_ready", in_ready, 1'b1);
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_outs", {out_mant, out_exp, out_zero, out_denorm}, '0);
    rst = 1'b0;
    @(negedge clk);
    chk("post_rst_idle", {in_ready, busy}, 2'b10);
    run(55'd1 << 54, 11'd100, 55'd1 << 54, 100, 1'b0, 1'b0, 2);
    run(55'd1, 11'd1000, 55'd1 << 54, 946, 1'b0, 1'b0, 6);
    run(55'd0, 11'd500, 55'd0, 0, 1'b1, 1'b0, 2);
    run(55'd1 << 10, 11'd20, 55'd1 << 30, 0, 1'b0, 1'b1, 4);
    run(55'd5, 11'd0, 55'd5, 0, 1'b0, 1'b1, 2);
    run(55'd1 << 50, 11'd4, 55'd1 << 54, 0, 1'b0, 1'b1, 3);
    run(55'd1 << 50, 11'd5, 55'd1 << 54, 1, 1'b0, 1'b0, 3);
    run(55'd1 << 38, 11'd100, 55'd1 << 54, 84, 1'b0, 1'b0, 3);
    run(55'd1 << 37, 11'd100, 55'd1 << 54, 83, 1'b0, 1'b0, 4);
    run({W{1'b1}}, 11'd3, {W{1'b1}}, 3, 1'b0, 1'b0, 2);
    start(55'd3, 11'd10);
    wait_done(3);
    in_valid = 1'b1; in_mant = 55'd7; in_exp = 11'd9;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk("hold_outs", {out_valid, out_mant, out_exp, out_zero, out_denorm},
          {1'b1, 55'd3 << 10, 11'd0, 1'b0, 1'b1});
      chk("hold_in_ready", in_ready, 1'b0);
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    in_valid = 1'b0;
    chk("hold_idle", {in_ready, out_valid, busy}, 3'b100);
    @(negedge clk);
    chk("hold_no_accept", {in_ready, busy}, 2'b10);
    start(55'd1, 11'd1000);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("midrst_idle", {in_ready, out_valid, busy}, 3'b100);
    chk("midrst_outs", {out_mant, out_exp, out_zero, out_denorm}, '0);
    run(55'd1 << 54, 11'd100, 55'd1 << 54, 100, 1'b0, 1'b0, 2);
    repeat (2) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/fpu_norm_seq.md
FPU_NORM_SEQ -- requirements
Module: fpu_norm_seq

Interface
REQ-001 SHALL have parameter WIDTH, default 55: mantissa width in bits.
REQ-002 SHALL have parameter WIDTH_LOG, default 6: leading-one index width; 2**WIDTH_LOG >= WIDTH.
REQ-003 SHALL have parameter EXP_W, default 11: exponent width, unsigned.
REQ-004 SHALL have parameter STEP, default 16: maximum left-shift bits per SHIFT cycle; STEP >= 1.
REQ-005 SHALL have port clk, input, 1: single clock; all state updates on its rising edge.
REQ-006 SHALL have port rst, input, 1: synchronous, active-high reset.
REQ-007 SHALL have port in_valid, input, 1: operand offered.
REQ-008 SHALL have port in_ready, output, 1: block can accept an operand.
REQ-009 SHALL have port in_mant, input, WIDTH: unnormalized mantissa.
REQ-010 SHALL have port in_exp, input, EXP_W: exponent of in_mant.
REQ-011 SHALL have port out_valid, output, 1: result available.
REQ-012 SHALL have port out_ready, input, 1: consumer accepts the result.
REQ-013 SHALL have port out_mant, output, WIDTH: normalized mantissa.
REQ-014 SHALL have port out_exp, output, EXP_W: adjusted exponent.
REQ-015 SHALL have port out_zero, output, 1: operand mantissa was zero.
REQ-016 SHALL have port out_denorm, output, 1: shift was clamped by the exponent.
REQ-017 SHALL have port busy, output, 1: state is not IDLE.

Function
REQ-018 SHALL implement a four-state FSM with states IDLE, ENC, SHIFT and DONE.
REQ-019 SHALL drive in_ready=1 only in IDLE, and accept an operand when in_valid and in_ready are both 1, registering in_mant and in_exp and moving to ENC.
REQ-020 SHALL compute the leading-one index idx in ENC with one fpu_pri_encoder instance (WIDTH=2**WIDTH_LOG, WIDTH_LOG=WIDTH_LOG, registered mantissa zero-extended), using msb[WIDTH_LOG-1:0].
REQ-021 SHALL detect zero mantissa with a separate OR-reduction and not rely on the encoder output for it.
REQ-022 SHALL set lz = WIDTH-1-idx; if lz < exp, then sh=lz, exp_out=exp-lz and denorm=0; otherwise sh=exp, exp_out=0 and denorm=1.
REQ-023 SHALL, for a zero mantissa in ENC, set out_mant=0, out_exp=0, out_zero=1, out_denorm=0 and go directly to DONE.
REQ-024 SHALL register sh into a remaining-shift counter in ENC, then go to SHIFT if sh>0, else to DONE.
REQ-025 SHALL, in each SHIFT cycle, left-shift the mantissa by min(rem,STEP), zero-filling, decrement rem by the same amount, and go to DONE when rem reaches 0.
REQ-026 SHALL assert out_valid only in DONE; first assertion is 2+ceil(sh/STEP) cycles after the accept edge.
REQ-027 SHALL hold out_mant, out_exp, out_zero and out_denorm stable while out_valid=1 and out_ready=0.
REQ-028 SHALL return from DONE to IDLE on the edge where out_ready=1, with no same-cycle bypass; a new accept occurs at the earliest one cycle later.
REQ-029 SHALL ignore in_valid in all states other than IDLE.
REQ-030 SHALL use unsigned exponent arithmetic that never wraps below 0.

Reset
REQ-031 SHALL, when rst=1 at a clock edge, enter IDLE from any state, including mid-SHIFT, and discard the operand in flight.
REQ-032 SHALL, after reset: in_ready=1, out_valid=0, busy=0, out_mant=0, out_exp=0, out_zero=0, out_denorm=0, rem=0.

Verification
REQ-033 SHALL cover: in_mant=1<<54, in_exp=100 -> out_valid 2 cycles after accept, out_mant=1<<54, out_exp=100, out_denorm=0.
REQ-034 SHALL cover: in_mant=1, in_exp=1000 -> 4 SHIFT cycles, out_valid at cycle 6, out_mant=1<<54, out_exp=946.
REQ-035 SHALL cover: in_mant=0, in_exp=500 -> out_valid at cycle 2, out_zero=1, out_mant=0, out_exp=0.
REQ-036 SHALL cover: in_mant=1<<10, in_exp=20 -> sh=20, 2 SHIFT cycles, out_valid at cycle 4, out_mant=1<<30, out_exp=0, out_denorm=1.
REQ-037 SHALL cover: out_ready held 0 for 5 cycles in DONE while in_valid=1 -> outputs unchanged, in_ready=0, no second accept; IDLE one cycle after out_ready=1.
REQ-038 SHALL cover: rst pulsed during the second SHIFT cycle of the REQ-034 case -> next cycle IDLE, out_valid=0, in_ready=1, and a following operand processes correctly.
